// File: rtl/mult_karatsuba_axis_pkg.sv
// Shared defaults and elaboration helpers for the Karatsuba multiply stage.
// Imported by the top level; mult_pipe is generic and needs none of it.
package mult_karatsuba_axis_pkg;

    localparam int KARA_WIDTH_DEFAULT    = 64;
    localparam int KARA_MULT_LAT_DEFAULT = 2;

    // Acceptance-to-valid latency: split stage, operand register, LAT product stages, combine, output.
    function automatic int kara_latency(input int mult_lat);
        return mult_lat + 3;
    endfunction

    function automatic bit kara_width_ok(input int width);
        return (width >= 4) && (width % 2 == 0);
    endfunction

endpackage

// File: rtl/mult_karatsuba_axis_mult_pipe.sv
// Unsigned W x W pipelined multiplier with clock enable and valid pass-through.
// Operands are registered on entry, followed by LAT product register stages.
module mult_pipe #(
    parameter int W   = 32,
    parameter int LAT = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           in_valid,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    output logic [2*W-1:0] p
);

    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [LAT:0]   vld_q;
    logic [2*W-1:0] prod_q [1:LAT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
        end else if (en) begin
            vld_q <= {vld_q[LAT-1:0], in_valid};
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            a_q       <= a;
            b_q       <= b;
            prod_q[1] <= {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
            for (int i = 2; i <= LAT; i++) begin
                prod_q[i] <= prod_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[LAT];
    assign p         = prod_q[LAT];

endmodule

// File: rtl/mult_karatsuba_axis.sv
// One-level Karatsuba unsigned multiplier with joined A/B valid/ready inputs
// and a valid/ready product output; the whole pipeline advances on one enable.
module mult_karatsuba_axis
    import mult_karatsuba_axis_pkg::*;
#(
    parameter int WIDTH    = KARA_WIDTH_DEFAULT,
    parameter int MULT_LAT = KARA_MULT_LAT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   input_a_tdata,
    input  logic               input_a_tvalid,
    output logic               input_a_tready,
    input  logic [WIDTH-1:0]   input_b_tdata,
    input  logic               input_b_tvalid,
    output logic               input_b_tready,
    output logic [2*WIDTH-1:0] output_tdata,
    output logic               output_tvalid,
    input  logic               output_tready
);

    localparam int H = WIDTH / 2;

    if (!kara_width_ok(WIDTH) || kara_latency(MULT_LAT) < 4) begin : g_param_check
        $error("mult_karatsuba_axis: WIDTH must be even and >= 4, MULT_LAT must be >= 1");
    end

    logic               adv;
    logic               ready;
    logic               take;
    logic [H-1:0]       ah_p0, al_p0, bh_p0, bl_p0;
    logic [H:0]         sa_p0, sb_p0;
    logic               vld_p0;
    logic [WIDTH-1:0]   ph_p1, pl_p1;
    logic [WIDTH+1:0]   pm_p1;
    logic               vh_p1, vl_p1, vm_p1, vld_p1;
    logic [WIDTH-1:0]   ph_p2, pl_p2;
    logic [WIDTH+1:0]   mid_p2;
    logic               vld_p2;
    logic [2*WIDTH-1:0] result;

    // Since pl < 2^WIDTH, Ph<<WIDTH + Pl is a plain concatenation; only Mid needs an add.
    function automatic logic [2*WIDTH-1:0] combine(input logic [WIDTH-1:0] ph,
                                                   input logic [WIDTH-1:0] pl,
                                                   input logic [WIDTH+1:0] mid);
        logic [2*WIDTH-1:0] mid_sh;
        mid_sh             = '0;
        mid_sh[H +: WIDTH+2] = mid;
        return {ph, pl} + mid_sh;
    endfunction

    assign adv            = !output_tvalid || output_tready;
    assign ready          = adv && rst;
    assign input_a_tready = ready;
    assign input_b_tready = ready;
    assign take           = input_a_tvalid && input_b_tvalid && ready;

    // S0: split operands and form the half sums
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p0 <= 1'b0;
        end else if (adv) begin
            vld_p0 <= take;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            ah_p0 <= input_a_tdata[WIDTH-1:H];
            al_p0 <= input_a_tdata[H-1:0];
            bh_p0 <= input_b_tdata[WIDTH-1:H];
            bl_p0 <= input_b_tdata[H-1:0];
            sa_p0 <= {1'b0, input_a_tdata[WIDTH-1:H]} + {1'b0, input_a_tdata[H-1:0]};
            sb_p0 <= {1'b0, input_b_tdata[WIDTH-1:H]} + {1'b0, input_b_tdata[H-1:0]};
        end
    end

    // S1..S(MULT_LAT): three sub-multipliers
    mult_pipe #(.W(H), .LAT(MULT_LAT)) u_mul_hi (
        .clk      (clk),
        .rst      (rst),
        .en       (adv),
        .in_valid (vld_p0),
        .a        (ah_p0),
        .b        (bh_p0),
        .out_valid(vh_p1),
        .p        (ph_p1)
    );

    mult_pipe #(.W(H), .LAT(MULT_LAT)) u_mul_lo (
        .clk      (clk),
        .rst      (rst),
        .en       (adv),
        .in_valid (vld_p0),
        .a        (al_p0),
        .b        (bl_p0),
        .out_valid(vl_p1),
        .p        (pl_p1)
    );

    mult_pipe #(.W(H + 1), .LAT(MULT_LAT)) u_mul_mid (
        .clk      (clk),
        .rst      (rst),
        .en       (adv),
        .in_valid (vld_p0),
        .a        (sa_p0),
        .b        (sb_p0),
        .out_valid(vm_p1),
        .p        (pm_p1)
    );

    assign vld_p1 = vh_p1 & vl_p1 & vm_p1;

    // SC: middle term, never negative and fits WIDTH+2 bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p2 <= 1'b0;
        end else if (adv) begin
            vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            ph_p2  <= ph_p1;
            pl_p2  <= pl_p1;
            mid_p2 <= pm_p1 - {2'b00, ph_p1} - {2'b00, pl_p1};
        end
    end

    assign result = combine(ph_p2, pl_p2, mid_p2);

    // SO: output register, holds while stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            output_tvalid <= 1'b0;
            output_tdata  <= '0;
        end else if (adv) begin
            output_tvalid <= vld_p2;
            if (vld_p2) begin
                output_tdata <= result;
            end
        end
    end

endmodule

// File: tb/tb_mult_karatsuba_axis.sv
// Bench for mult_karatsuba_axis: directed handshake/latency cases plus
// randomized traffic on 64/32/8-bit instances against a plain product model.
module tb_mult_karatsuba_axis;

    localparam int NRAND = 10000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [63:0]  a  [3];
    logic [63:0]  b  [3];
    logic         av [3];
    logic         bv [3];
    logic         yr [3];
    logic         ra0, rb0, ra1, rb1, ra2, rb2;
    logic         yv0, yv1, yv2;
    logic [127:0] y0;
    logic [63:0]  y1;
    logic [15:0]  y2;

    int tests = 0;
    int fails = 0;

    mult_karatsuba_axis #(.WIDTH(64), .MULT_LAT(2)) u_dut64 (
        .clk(clk), .rst(rst),
        .input_a_tdata(a[0]), .input_a_tvalid(av[0]), .input_a_tready(ra0),
        .input_b_tdata(b[0]), .input_b_tvalid(bv[0]), .input_b_tready(rb0),
        .output_tdata(y0), .output_tvalid(yv0), .output_tready(yr[0])
    );

    mult_karatsuba_axis #(.WIDTH(32), .MULT_LAT(1)) u_dut32 (
        .clk(clk), .rst(rst),
        .input_a_tdata(a[1][31:0]), .input_a_tvalid(av[1]), .input_a_tready(ra1),
        .input_b_tdata(b[1][31:0]), .input_b_tvalid(bv[1]), .input_b_tready(rb1),
        .output_tdata(y1), .output_tvalid(yv1), .output_tready(yr[1])
    );

    mult_karatsuba_axis #(.WIDTH(8), .MULT_LAT(3)) u_dut8 (
        .clk(clk), .rst(rst),
        .input_a_tdata(a[2][7:0]), .input_a_tvalid(av[2]), .input_a_tready(ra2),
        .input_b_tdata(b[2][7:0]), .input_b_tvalid(bv[2]), .input_b_tready(rb2),
        .output_tdata(y2), .output_tvalid(yv2), .output_tready(yr[2])
    );

    function automatic int f_w(input int i);
        return (i == 0) ? 64 : (i == 1) ? 32 : 8;
    endfunction

    function automatic int f_lat(input int i);
        return (i == 0) ? 2 : (i == 1) ? 1 : 3;
    endfunction

    function automatic logic f_yv(input int i);
        return (i == 0) ? yv0 : (i == 1) ? yv1 : yv2;
    endfunction

    function automatic logic f_ra(input int i);
        return (i == 0) ? ra0 : (i == 1) ? ra1 : ra2;
    endfunction

    function automatic logic f_rb(input int i);
        return (i == 0) ? rb0 : (i == 1) ? rb1 : rb2;
    endfunction

    function automatic logic [127:0] f_y(input int i);
        return (i == 0) ? y0 : (i == 1) ? {64'b0, y1} : {112'b0, y2};
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at the first negedge after acceptance; lat = edges after the acceptance edge.
    task automatic wait_out(input int i, output int lat, output logic [127:0] d);
        lat = -1;
        d   = '0;
        for (int n = 0; n < 40; n++) begin
            if (f_yv(i)) begin
                lat = n;
                d   = f_y(i);
                break;
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic count_outputs(input int i, input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk); #1;
            if (f_yv(i)) cnt++;
        end
    endtask

    task automatic send_one(input int i, input logic [63:0] va, input logic [63:0] vb,
                            output int lat, output logic [127:0] d);
        @(negedge clk);
        a[i] = va; b[i] = vb; av[i] = 1'b1; bv[i] = 1'b1; yr[i] = 1'b1;
        #1;
        check($sformatf("send%0d_rdy", i), f_ra(i), 1);
        @(negedge clk);
        av[i] = 1'b0; bv[i] = 1'b0;
        #1;
        wait_out(i, lat, d);
    endtask

    task automatic rand_run(input int i);
        logic [63:0]  mask;
        logic [127:0] q [$];
        int acc;
        int cyc;
        acc  = 0;
        cyc  = 0;
        mask = (f_w(i) == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << f_w(i)) - 64'd1);
        while ((acc < NRAND || q.size() != 0) && cyc < 40000) begin
            @(negedge clk);
            if (acc < NRAND) begin
                a[i]  = ($urandom_range(0, 15) == 0) ? mask : ({$urandom, $urandom} & mask);
                b[i]  = ($urandom_range(0, 15) == 0) ? mask : ({$urandom, $urandom} & mask);
                av[i] = ($urandom_range(0, 7) != 0);
                bv[i] = ($urandom_range(0, 7) != 0);
            end else begin
                av[i] = 1'b0;
                bv[i] = 1'b0;
            end
            yr[i] = ($urandom_range(0, 7) != 0);
            #1;
            if (f_yv(i) && yr[i]) begin
                if (q.size() == 0) check($sformatf("rand%0d_extra", i), f_yv(i), 0);
                else               check($sformatf("rand%0d_prod", i), f_y(i), q.pop_front());
            end
            if (av[i] && bv[i] && f_ra(i)) begin
                q.push_back({64'b0, a[i]} * {64'b0, b[i]});
                acc++;
            end
            cyc++;
        end
        check($sformatf("rand%0d_accepted", i), acc, NRAND);
        check($sformatf("rand%0d_pending", i), q.size(), 0);
        av[i] = 1'b0;
        bv[i] = 1'b0;
        yr[i] = 1'b1;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat;
        int           cnt;
        int           n_in;
        int           n_out;
        int           cyc;
        bit           first_stall;
        logic [127:0] d;
        logic [127:0] held;

        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a[i] = '0; b[i] = '0; av[i] = 1'b0; bv[i] = 1'b0; yr[i] = 1'b1;
        end
        held = '0;

        // Reset with both valids high
        a[0] = 64'h1234; b[0] = 64'h5678; av[0] = 1'b1; bv[0] = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_rdy_a", ra0, 0);
        check("rst_rdy_b", rb0, 0);
        check("rst_vld", yv0, 0);
        check("rst_data", y0, 0);
        @(negedge clk);
        av[0] = 1'b0; bv[0] = 1'b0; rst = 1'b1;
        #1;
        check("rel_rdy", ra0, 1);
        count_outputs(0, 10, cnt);
        check("rel_ghost", cnt, 0);

        // Corner product
        send_one(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, lat, d);
        check("corner_lat", lat, 5);
        check("corner_data", d, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);

        // Join: lone A must not be consumed
        @(negedge clk);
        a[0] = 64'd3; av[0] = 1'b1; bv[0] = 1'b0;
        #1;
        check("join_rdy_a", ra0, 1);
        check("join_rdy_b", rb0, 1);
        count_outputs(0, 3, cnt);
        check("join_lone", cnt, 0);
        b[0] = 64'd5; bv[0] = 1'b1;
        @(negedge clk);
        av[0] = 1'b0; bv[0] = 1'b0;
        #1;
        wait_out(0, lat, d);
        check("join_lat", lat, 5);
        check("join_data", d, 128'd15);
        count_outputs(0, 10, cnt);
        check("join_dup", cnt, 0);

        // Backpressure: i*(i+1), stall 4 cycles mid-stream
        n_in = 0; n_out = 0; cyc = 0; first_stall = 1'b1;
        while (n_out < 8 && cyc < 80) begin
            @(negedge clk);
            if (n_in < 8) begin
                a[0] = 64'(n_in); b[0] = 64'(n_in + 1); av[0] = 1'b1; bv[0] = 1'b1;
            end else begin
                av[0] = 1'b0; bv[0] = 1'b0;
            end
            yr[0] = !(cyc >= 6 && cyc < 10);
            #1;
            if (yv0 && !yr[0]) begin
                check("bp_stall_rdy", ra0, 0);
                if (first_stall) begin
                    held        = y0;
                    first_stall = 1'b0;
                end else begin
                    check("bp_stable", y0, held);
                end
            end
            if (yv0 && yr[0]) begin
                check($sformatf("bp_out%0d", n_out), y0, 128'(n_out) * 128'(n_out + 1));
                n_out++;
            end
            if (av[0] && bv[0] && ra0) n_in++;
            cyc++;
        end
        av[0] = 1'b0; bv[0] = 1'b0; yr[0] = 1'b1;
        check("bp_in_count", n_in, 8);
        check("bp_out_count", n_out, 8);
        check("bp_stalled", first_stall, 0);
        count_outputs(0, 10, cnt);
        check("bp_dup", cnt, 0);

        // Reset mid-flight
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a[0] = 64'(k + 11); b[0] = 64'(k + 20); av[0] = 1'b1; bv[0] = 1'b1;
        end
        @(negedge clk);
        av[0] = 1'b0; bv[0] = 1'b0; rst = 1'b0;
        #1;
        check("mid_rst_rdy", ra0, 0);
        @(negedge clk);
        rst = 1'b1;
        count_outputs(0, 12, cnt);
        check("mid_rst_ghost", cnt, 0);
        send_one(0, 64'd7, 64'd9, lat, d);
        check("mid_rst_lat", lat, 5);
        check("mid_rst_data", d, 128'd63);

        // 32-bit, MULT_LAT=1 instance
        send_one(1, 64'hFFFF_FFFF, 64'd2, lat, d);
        check("w32_lat", lat, f_lat(1) + 3);
        check("w32_data", d, 128'h1_FFFF_FFFE);

        fork
            rand_run(0);
            rand_run(1);
            rand_run(2);
        join

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
